// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register from the consuming side, issues one
// instruction-memory read at a time and buffers the returned word for decode.
// Optional build macro FETCH_PERF_EN adds fetch/stall performance counters.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned PC_STEP = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_en,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [ADDR_W-1:0]  inst_pc,
    input  logic               inst_ready,
    input  logic               redirect,
`ifdef FETCH_PERF_EN
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`else
    input  logic [ADDR_W-1:0]  redirect_target
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StHold,
        StDrain,
        StRedir
    } state_e;

    state_e r_state;
    state_e w_state;

    logic               r_pc_en,      w_pc_en;
    logic [ADDR_W-1:0]  r_next_pc,    w_next_pc;
    logic               r_imem_req,   w_imem_req;
    logic [ADDR_W-1:0]  r_imem_addr,  w_imem_addr;
    logic               r_inst_valid, w_inst_valid;
    logic [INSTR_W-1:0] r_inst,       w_inst;
    logic [ADDR_W-1:0]  r_inst_pc,    w_inst_pc;

    logic               w_ack;
    logic [ADDR_W-1:0]  w_addr_inc;

    // An ack only counts while a request is actually outstanding.
    assign w_ack      = imem_ack && r_imem_req;
    assign w_addr_inc = r_imem_addr + ADDR_W'(PC_STEP);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_state;
    end

    // Next-state selection; redirect outranks everything but reset.
    always_comb begin
        w_state = r_state;
        if (redirect) begin
            unique case (r_state)
                StWait:  w_state = w_ack ? StRedir : StDrain;
                StDrain: w_state = w_ack ? StRedir : StDrain;
                default: w_state = StRedir;
            endcase
        end else begin
            unique case (r_state)
                StIdle:  w_state = StIssue;
                StIssue: w_state = StWait;
                StWait:  w_state = w_ack ? StHold : StWait;
                StHold:  w_state = (r_inst_valid && inst_ready) ? StIssue : StHold;
                StDrain: w_state = w_ack ? StIssue : StDrain;
                StRedir: w_state = StIssue;
                default: w_state = StIdle;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_pc_en      = 1'b0;
        w_next_pc    = r_next_pc;
        w_imem_req   = r_imem_req;
        w_imem_addr  = r_imem_addr;
        w_inst_valid = r_inst_valid;
        w_inst       = r_inst;
        w_inst_pc    = r_inst_pc;
        if (redirect) begin
            w_pc_en      = 1'b1;
            w_next_pc    = redirect_target;
            w_inst_valid = 1'b0;
            // Any data returning with the redirect belongs to the old path.
            if (w_ack) w_imem_req = 1'b0;
        end else begin
            unique case (r_state)
                StIssue: begin
                    w_imem_addr = pc;
                    w_imem_req  = 1'b1;
                end
                StWait: begin
                    if (w_ack) begin
                        w_inst       = imem_rdata;
                        w_inst_pc    = r_imem_addr;
                        w_inst_valid = 1'b1;
                        w_imem_req   = 1'b0;
                        w_pc_en      = 1'b1;
                        w_next_pc    = w_addr_inc;
                    end
                end
                StHold: begin
                    if (r_inst_valid && inst_ready) w_inst_valid = 1'b0;
                end
                StDrain: begin
                    if (w_ack) w_imem_req = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc_en      <= 1'b0;
            r_next_pc    <= '0;
            r_imem_req   <= 1'b0;
            r_imem_addr  <= '0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_pc_en      <= w_pc_en;
            r_next_pc    <= w_next_pc;
            r_imem_req   <= w_imem_req;
            r_imem_addr  <= w_imem_addr;
            r_inst_valid <= w_inst_valid;
            r_inst       <= w_inst;
            r_inst_pc    <= w_inst_pc;
        end
    end

    assign pc_en      = r_pc_en;
    assign next_pc    = r_next_pc;
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_imem_addr;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Saturating counters for handshakes and memory-wait cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_inst_valid && inst_ready && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (((r_state == StWait) || (r_state == StDrain)) && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a PC register and a simple
// latency-programmable instruction memory around the DUT.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        pc_en;
    logic [15:0] next_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        redirect;
    logic [15:0] redirect_target;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int unsigned lat;
    int unsigned cnt;
    logic        stray_ack;
    int          n_checks;
    int          n_pass;

    fetch_sequencer #(
        .ADDR_W (16),
        .INSTR_W(16),
        .PC_STEP(1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc),
        .pc_en          (pc_en),
        .next_pc        (next_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect       (redirect),
`ifdef FETCH_PERF_EN
        .redirect_target(redirect_target),
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`else
        .redirect_target(redirect_target)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // PC register owned by the environment.
    always @(posedge clock) begin
        if (reset)      pc <= 16'h0000;
        else if (pc_en) pc <= next_pc;
    end

    // Memory: ack in the lat-th cycle of a request, plus an injectable stray ack.
    always @(posedge clock) begin
        if (reset || !imem_req || imem_ack) cnt <= 0;
        else                                cnt <= cnt + 1;
    end
    assign imem_ack   = (imem_req && (cnt == lat - 1)) || stray_ack;
    assign imem_rdata = rd(imem_addr);

    function automatic logic [15:0] rd(input logic [15:0] a);
        return 16'hA5C3 ^ a;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        inst_ready      = 1'b1;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        stray_ack       = 1'b0;
        lat             = 1;
        tick();
        tick();
        check("rst_pc_en", 32'(pc_en), 32'h0);
        check("rst_next_pc", 32'(next_pc), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", 32'(inst), 32'h0);
        check("rst_inst_pc", 32'(inst_pc), 32'h0);
        reset = 1'b0;

        // Sequential fetches, 1-cycle ack, ready high: one per 3 cycles.
        tick();
        check("idle_req", 32'(imem_req), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("seq_req", 32'(imem_req), 32'h1);
            check("seq_addr", 32'(imem_addr), 32'(k));
            tick();
            check("seq_valid", 32'(inst_valid), 32'h1);
            check("seq_inst_pc", 32'(inst_pc), 32'(k));
            check("seq_inst", 32'(inst), 32'(rd(16'(k))));
            check("seq_pc_en", 32'(pc_en), 32'h1);
            check("seq_next_pc", 32'(next_pc), 32'(k + 1));
            check("seq_req_drop", 32'(imem_req), 32'h0);
            tick();
            check("seq_pc_en_off", 32'(pc_en), 32'h0);
            check("seq_valid_off", 32'(inst_valid), 32'h0);
        end

        // Ack latency 4 at address 5, then decode stalls for 6 cycles.
        lat = 4;
        tick();
        check("l4_req", 32'(imem_req), 32'h1);
        check("l4_addr", 32'(imem_addr), 32'h5);
`ifdef FETCH_PERF_EN
        check("l4_stall_before", stall_count, 32'd5);
`endif
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("l4_req_hold", 32'(imem_req), 32'h1);
            check("l4_addr_hold", 32'(imem_addr), 32'h5);
            check("l4_valid_low", 32'(inst_valid), 32'h0);
        end
        tick();
        check("l4_valid", 32'(inst_valid), 32'h1);
        check("l4_inst", 32'(inst), 32'(rd(16'h5)));
        check("l4_inst_pc", 32'(inst_pc), 32'h5);
        check("l4_req_drop", 32'(imem_req), 32'h0);
        check("l4_next_pc", 32'(next_pc), 32'h6);
`ifdef FETCH_PERF_EN
        check("l4_stall_after", stall_count, 32'd9);
`endif
        stray_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            stray_ack = 1'b0;
            check("stall_valid", 32'(inst_valid), 32'h1);
            check("stall_inst", 32'(inst), 32'(rd(16'h5)));
            check("stall_inst_pc", 32'(inst_pc), 32'h5);
            check("stall_req", 32'(imem_req), 32'h0);
            check("stall_pc_en", 32'(pc_en), 32'h0);
        end
        inst_ready = 1'b1;
        lat = 3;
        tick();
        check("rdy_valid_off", 32'(inst_valid), 32'h0);
        check("rdy_req", 32'(imem_req), 32'h0);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'd6);
`endif

        // Redirect in first WAIT cycle of a 3-cycle ack: drain and discard.
        tick();
        check("drn_req", 32'(imem_req), 32'h1);
        check("drn_addr", 32'(imem_addr), 32'h6);
        redirect        = 1'b1;
        redirect_target = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drn_pc_en", 32'(pc_en), 32'h1);
        check("drn_next_pc", 32'(next_pc), 32'h40);
        check("drn_req_held", 32'(imem_req), 32'h1);
        check("drn_addr_held", 32'(imem_addr), 32'h6);
        tick();
        check("drn_pc_en_off", 32'(pc_en), 32'h0);
        check("drn_req_held2", 32'(imem_req), 32'h1);
        tick();
        check("drn_req_drop", 32'(imem_req), 32'h0);
        check("drn_valid", 32'(inst_valid), 32'h0);
        check("drn_inst_kept", 32'(inst), 32'(rd(16'h5)));
        check("drn_next_pc_kept", 32'(next_pc), 32'h40);
        tick();
        check("drn_refetch_req", 32'(imem_req), 32'h1);
        check("drn_refetch_addr", 32'(imem_addr), 32'h40);
`ifdef FETCH_PERF_EN
        check("drn_stall", stall_count, 32'd12);
`endif

        // Redirect in the same cycle as the ack.
        lat             = 1;
        redirect        = 1'b1;
        redirect_target = 16'h0100;
        tick();
        redirect = 1'b0;
        check("same_valid", 32'(inst_valid), 32'h0);
        check("same_pc_en", 32'(pc_en), 32'h1);
        check("same_next_pc", 32'(next_pc), 32'h100);
        check("same_req", 32'(imem_req), 32'h0);
        tick();
        check("same_pc_en_off", 32'(pc_en), 32'h0);
        check("same_next_pc_kept", 32'(next_pc), 32'h100);
        check("same_valid_off", 32'(inst_valid), 32'h0);
        tick();
        check("same_refetch_addr", 32'(imem_addr), 32'h100);
        check("same_refetch_req", 32'(imem_req), 32'h1);
        tick();
        check("same_inst_pc", 32'(inst_pc), 32'h100);
        check("same_next_inc", 32'(next_pc), 32'h101);

        // Redirect from HOLD to 0xFFFF, then wrap.
        redirect        = 1'b1;
        redirect_target = 16'hFFFF;
        tick();
        redirect = 1'b0;
        check("wrap_valid_drop", 32'(inst_valid), 32'h0);
        check("wrap_next_pc", 32'(next_pc), 32'hFFFF);
        tick();
        tick();
        check("wrap_addr", 32'(imem_addr), 32'hFFFF);
        tick();
        check("wrap_inst_pc", 32'(inst_pc), 32'hFFFF);
        check("wrap_next_pc0", 32'(next_pc), 32'h0);
        check("wrap_pc_en", 32'(pc_en), 32'h1);
        tick();
        tick();
        check("wrap_refetch", 32'(imem_addr), 32'h0);
        tick();
        check("wrap2_next_pc", 32'(next_pc), 32'h1);
        tick();
        lat = 3;
        tick();
        check("rw_req", 32'(imem_req), 32'h1);
        check("rw_addr", 32'(imem_addr), 32'h1);

        // Reset mid-WAIT.
        reset = 1'b1;
        tick();
        check("mrst_pc_en", 32'(pc_en), 32'h0);
        check("mrst_next_pc", 32'(next_pc), 32'h0);
        check("mrst_req", 32'(imem_req), 32'h0);
        check("mrst_addr", 32'(imem_addr), 32'h0);
        check("mrst_valid", 32'(inst_valid), 32'h0);
        check("mrst_inst", 32'(inst), 32'h0);
        check("mrst_inst_pc", 32'(inst_pc), 32'h0);
`ifdef FETCH_PERF_EN
        check("mrst_fetch_count", fetch_count, 32'h0);
        check("mrst_stall_count", stall_count, 32'h0);
`endif
        reset = 1'b0;
        lat   = 1;
        tick();
        tick();
        check("restart_req", 32'(imem_req), 32'h1);
        check("restart_addr", 32'(imem_addr), 32'h0);
        tick();
        check("restart_valid", 32'(inst_valid), 32'h1);
        check("restart_inst_pc", 32'(inst_pc), 32'h0);
        check("restart_next_pc", 32'(next_pc), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
